// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding, FSM
// states, accumulate modes and default sizing.
package ex_muldiv_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int MUL_LAT_DEF = 3;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ACC_NONE = 2'd0,
      ACC_ADD  = 2'd1,
      ACC_SUB  = 2'd2
   } acc_e;

endpackage

// File: rtl/ex_div_core.sv
// Iterative restoring divider: unsigned core on operand magnitudes, one
// quotient bit per edge, with sign and divide-by-zero fix-up on the outputs.
module ex_div_core
   import ex_muldiv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic              annul_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic              last_o,
   output logic              dz_o,
   output logic [DATA_W-1:0] quo_o,
   output logic [DATA_W-1:0] rem_o
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic              run_q, run_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              dz_q, dz_d;

   logic              s1_neg, s2_neg;
   logic [DATA_W:0]   r_shift, diff;

   always_comb begin
      s1_neg  = signed_i & dividend_i[DATA_W-1];
      s2_neg  = signed_i & divisor_i[DATA_W-1];
      r_shift = {rem_q, quo_q[DATA_W-1]};
      diff    = r_shift - {1'b0, dvs_q};
   end

   always_comb begin
      run_d  = run_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      dvd_d  = dvd_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      dz_d   = dz_q;
      if (annul_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         run_d  = 1'b1;
         cnt_d  = '0;
         rem_d  = '0;
         quo_d  = s1_neg ? -dividend_i : dividend_i;
         dvs_d  = s2_neg ? -divisor_i : divisor_i;
         dvd_d  = dividend_i;
         qneg_d = s1_neg ^ s2_neg;
         rneg_d = s1_neg;
         dz_d   = (divisor_i == '0);
      end else if (run_q) begin
         // Restore by keeping the shifted remainder when the trial goes negative.
         if (diff[DATA_W]) begin
            rem_d = r_shift[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
         end else begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
         end
         cnt_d = cnt_q + 1'b1;
         if (last_o) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q  <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         dvd_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         run_q  <= run_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         dvd_q  <= dvd_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         dz_q   <= dz_d;
      end
   end

   always_comb begin
      last_o = run_q && (cnt_q == CW'(DATA_W - 1));
      dz_o   = dz_q;
      quo_o  = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
      rem_o  = dz_q ? dvd_q : (rneg_q ? -rem_q : rem_q);
   end

endmodule

// File: rtl/ex_hilo_muldiv.sv
// Multi-cycle HI/LO execute unit: pipelined multiply, iterative divide, MTHI/MTLO.
// Define EX_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulation into {HI,LO}.
module ex_hilo_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] src1_i,
   input  logic [DATA_W-1:0] src2_i,
   input  logic              annul_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              dz_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int PW = 2 * DATA_W;
   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic              done_q, done_d, dz_q, dz_d;
   logic [CW-1:0]     mcnt_q, mcnt_d;
   logic [MUL_LAT-1:0][PW-1:0] pipe_q, pipe_d;

   logic              mul_op, mul_sgn, acc_mul, acc_div, mul_last, idle;
   logic [PW-1:0]     a_ext, b_ext, prod_now, mul_res;
   logic              div_last, div_dz;
   logic [DATA_W-1:0] div_quo, div_rem;
`ifdef EX_MADD_EN
   acc_e              acc_mode, acc_q, acc_d;
`endif

   always_comb begin
      mul_op  = 1'b0;
      mul_sgn = 1'b0;
`ifdef EX_MADD_EN
      acc_mode = ACC_NONE;
`endif
      case (op_i)
         OP_MULT:  begin mul_op = 1'b1; mul_sgn = 1'b1; end
         OP_MULTU: begin mul_op = 1'b1; end
`ifdef EX_MADD_EN
         OP_MADD:  begin mul_op = 1'b1; mul_sgn = 1'b1; acc_mode = ACC_ADD; end
         OP_MADDU: begin mul_op = 1'b1; acc_mode = ACC_ADD; end
         OP_MSUB:  begin mul_op = 1'b1; mul_sgn = 1'b1; acc_mode = ACC_SUB; end
         OP_MSUBU: begin mul_op = 1'b1; acc_mode = ACC_SUB; end
`endif
         default: ;
      endcase
      idle     = (state_q == ST_IDLE);
      acc_mul  = start_i && idle && mul_op;
      acc_div  = start_i && idle && ((op_i == OP_DIV) || (op_i == OP_DIVU));
      mul_last = (mcnt_q == CW'(MUL_LAT - 1));
      // Extending to full product width makes a plain truncated multiply exact.
      a_ext    = mul_sgn ? {{DATA_W{src1_i[DATA_W-1]}}, src1_i} : {{DATA_W{1'b0}}, src1_i};
      b_ext    = mul_sgn ? {{DATA_W{src2_i[DATA_W-1]}}, src2_i} : {{DATA_W{1'b0}}, src2_i};
      prod_now = a_ext * b_ext;
   end

   always_comb begin
      pipe_d = pipe_q;
      if (acc_mul) begin
         pipe_d[0] = prod_now;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // HI/LO are read at the write edge so a preceding MTHI/MTLO is accumulated.
   always_comb begin
      mul_res = pipe_q[MUL_LAT-1];
`ifdef EX_MADD_EN
      case (acc_q)
         ACC_ADD: mul_res = {hi_q, lo_q} + pipe_q[MUL_LAT-1];
         ACC_SUB: mul_res = {hi_q, lo_q} - pipe_q[MUL_LAT-1];
         default: ;
      endcase
`endif
   end

   ex_div_core #(
      .DATA_W (DATA_W)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (acc_div),
      .signed_i   (op_i == OP_DIV),
      .annul_i    (annul_i && !idle),
      .dividend_i (src1_i),
      .divisor_i  (src2_i),
      .last_o     (div_last),
      .dz_o       (div_dz),
      .quo_o      (div_quo),
      .rem_o      (div_rem)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (acc_mul) begin
               state_d = ST_MUL;
            end else if (acc_div) begin
               state_d = ST_DIV;
            end
         end
         ST_MUL: begin
            if (annul_i || mul_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_DIV: begin
            if (annul_i) begin
               state_d = ST_IDLE;
            end else if (div_last) begin
               state_d = ST_FIX;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q != ST_IDLE);
      done_o = done_q;
      dz_o   = dz_q;
      hi_o   = hi_q;
      lo_o   = lo_q;
   end

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      dz_d   = 1'b0;
      mcnt_d = mcnt_q;
`ifdef EX_MADD_EN
      acc_d  = acc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i && (op_i == OP_MTHI)) begin
               hi_d = src1_i;
            end
            if (start_i && (op_i == OP_MTLO)) begin
               lo_d = src1_i;
            end
            if (acc_mul) begin
               mcnt_d = '0;
`ifdef EX_MADD_EN
               acc_d  = acc_mode;
`endif
            end
         end
         ST_MUL: begin
            if (!annul_i) begin
               if (mul_last) begin
                  {hi_d, lo_d} = mul_res;
                  done_d       = 1'b1;
               end else begin
                  mcnt_d = mcnt_q + 1'b1;
               end
            end
         end
         ST_FIX: begin
            if (!annul_i) begin
               hi_d   = div_rem;
               lo_d   = div_quo;
               done_d = 1'b1;
               dz_d   = div_dz;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         mcnt_q <= '0;
         pipe_q <= '0;
`ifdef EX_MADD_EN
         acc_q  <= ACC_NONE;
`endif
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
         dz_q   <= dz_d;
         mcnt_q <= mcnt_d;
         pipe_q <= pipe_d;
`ifdef EX_MADD_EN
         acc_q  <= acc_d;
`endif
      end
   end

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Randomised and directed checks of ex_hilo_muldiv against an arithmetic model
// of HI/LO, busy window and done/dz pulses.
module tb_ex_hilo_muldiv;

   localparam int DW  = 32;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic [3:0]    op_i = 4'd0;
   logic [DW-1:0] src1_i = '0;
   logic [DW-1:0] src2_i = '0;
   logic          annul_i = 1'b0;
   logic          busy_o, done_o, dz_o;
   logic [DW-1:0] hi_o, lo_o;

   ex_hilo_muldiv #(.DATA_W(DW), .MUL_LAT(LAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .op_i    (op_i),
      .src1_i  (src1_i),
      .src2_i  (src2_i),
      .annul_i (annul_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .dz_o    (dz_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   bit last_dz = 1'b0;

   // Model state: result registers, edges left until the write, pending result.
   logic [DW-1:0] m_hi = '0, m_lo = '0;
   int            m_rem = 0;
   int            m_kind = 0;        // 0 plain mul, 1 add, 2 sub, 3 div
   logic [63:0]   m_p = '0;
   logic [DW-1:0] m_q = '0, m_r = '0;
   bit            m_pdz = 1'b0;
   bit            m_done = 1'b0, m_dz = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mulp(input bit sgn, input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return sa * sb;
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
   endfunction

   task automatic divm(input bit sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output logic [DW-1:0] q, output logic [DW-1:0] r, output bit dz);
      longint sa, sb;
      dz = 1'b0;
      if (b == 0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0; m_dz = 1'b0;
         end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_rem > 0) begin
               if (annul_i) begin
                  m_rem = 0;
               end else begin
                  m_rem--;
                  if (m_rem == 0) begin
                     case (m_kind)
                        0: {m_hi, m_lo} = m_p;
                        1: {m_hi, m_lo} = {m_hi, m_lo} + m_p;
                        2: {m_hi, m_lo} = {m_hi, m_lo} - m_p;
                        default: begin m_hi = m_r; m_lo = m_q; m_dz = m_pdz; end
                     endcase
                     m_done = 1'b1;
                  end
               end
            end else if (start_i) begin
               case (op_i)
                  4'd1: begin m_p = mulp(1'b1, src1_i, src2_i); m_kind = 0; m_rem = LAT; end
                  4'd2: begin m_p = mulp(1'b0, src1_i, src2_i); m_kind = 0; m_rem = LAT; end
                  4'd3: begin divm(1'b1, src1_i, src2_i, m_q, m_r, m_pdz); m_kind = 3; m_rem = DW + 1; end
                  4'd4: begin divm(1'b0, src1_i, src2_i, m_q, m_r, m_pdz); m_kind = 3; m_rem = DW + 1; end
                  4'd5: m_hi = src1_i;
                  4'd6: m_lo = src1_i;
`ifdef EX_MADD_EN
                  4'd7:  begin m_p = mulp(1'b1, src1_i, src2_i); m_kind = 1; m_rem = LAT; end
                  4'd8:  begin m_p = mulp(1'b0, src1_i, src2_i); m_kind = 1; m_rem = LAT; end
                  4'd9:  begin m_p = mulp(1'b1, src1_i, src2_i); m_kind = 2; m_rem = LAT; end
                  4'd10: begin m_p = mulp(1'b0, src1_i, src2_i); m_kind = 2; m_rem = LAT; end
`endif
                  default: ;
               endcase
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("busy", 64'(busy_o), 64'(m_rem > 0));
            chk("done", 64'(done_o), 64'(m_done));
            if (m_done) chk("dz", 64'(dz_o), 64'(m_dz));
            chk("hi", 64'(hi_o), 64'(m_hi));
            chk("lo", 64'(lo_o), 64'(m_lo));
            if (done_o) begin
               done_cnt++;
               last_dz = dz_o;
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit an);
      #1;
      start_i = 1'b1; op_i = op; src1_i = a; src2_i = b; annul_i = an;
      @(posedge clk);
      #1;
      start_i = 1'b0; annul_i = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      bit ok;
      ok  = 1'b0;
      cyc = 0;
      while (!ok && cyc < 200) begin
         @(negedge clk);
         if (busy_o) cyc++;
         else ok = 1'b1;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL wait_idle: busy still %0d after %0d cycles", busy_o, cyc);
      end
      #2;
   endtask

   int c, d0;
   logic [3:0] rop;
   logic [DW-1:0] ra, rb;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_dz", 64'(dz_o), 64'd0);
      chk("rst_hi", 64'(hi_o), 64'd0);
      chk("rst_lo", 64'(lo_o), 64'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      #2;

      d0 = done_cnt;
      issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
      wait_idle(c);
      chk("mult_lat", 64'(c), 64'(LAT));
      chk("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);
      chk("mult_done_pulses", 64'(done_cnt - d0), 64'd1);

      issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
      wait_idle(c);
      chk("multu_hi", 64'(hi_o), 64'h2);
      chk("multu_lo", 64'(lo_o), 64'hFFFF_FFFA);

      issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      wait_idle(c);
      chk("div_busy_cycles", 64'(c), 64'd33);
      chk("div_lo", 64'(lo_o), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi_o), 64'hFFFF_FFFF);

      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      wait_idle(c);
      chk("div_ovf_lo", 64'(lo_o), 64'h8000_0000);
      chk("div_ovf_hi", 64'(hi_o), 64'h0);

      issue(4'd4, 32'd100, 32'd0, 1'b0);
      wait_idle(c);
      chk("dz_busy_cycles", 64'(c), 64'd33);
      chk("dz_lo", 64'(lo_o), 64'hFFFF_FFFF);
      chk("dz_hi", 64'(hi_o), 64'h64);
      chk("dz_flag", 64'(last_dz), 64'd1);

      // Annul a divide mid-flight, then start a multiply the next cycle.
      d0 = done_cnt;
      issue(4'd3, 32'd1000, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      #1 annul_i = 1'b1;
      @(posedge clk);
      #1 annul_i = 1'b0;
      issue(4'd1, 32'd7, 32'd6, 1'b0);
      @(negedge clk);
      #1;
      chk("annul_then_mult_busy", 64'(busy_o), 64'd1);
      chk("annul_hi_kept", 64'(hi_o), 64'h64);
      chk("annul_lo_kept", 64'(lo_o), 64'hFFFF_FFFF);
      wait_idle(c);
      chk("annul_mult_lo", 64'(lo_o), 64'd42);
      chk("annul_done_pulses", 64'(done_cnt - d0), 64'd1);

      // A start while busy is dropped.
      issue(4'd2, 32'd9, 32'd5, 1'b0);
      issue(4'd3, 32'd100, 32'd3, 1'b0);
      wait_idle(c);
      chk("ignored_start_lat", 64'(c), 64'(LAT - 1));
      chk("ignored_start_lo", 64'(lo_o), 64'd45);

      issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
      wait_idle(c);
      chk("mthi_busy_cycles", 64'(c), 64'd0);
      chk("mthi_hi", 64'(hi_o), 64'h1234_5678);

      // Asynchronous reset in the middle of a divide.
      issue(4'd3, 32'd50, 32'd7, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_done", 64'(done_o), 64'd0);
      chk("arst_dz", 64'(dz_o), 64'd0);
      chk("arst_hi", 64'(hi_o), 64'd0);
      chk("arst_lo", 64'(lo_o), 64'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #2;

      issue(4'd6, 32'd5, 32'd0, 1'b0);
      wait_idle(c);
      issue(4'd5, 32'd0, 32'd0, 1'b0);
      wait_idle(c);
      issue(4'd7, 32'd2, 32'd3, 1'b0);
      wait_idle(c);
`ifdef EX_MADD_EN
      chk("madd_lo", 64'(lo_o), 64'd11);
      chk("madd_hi", 64'(hi_o), 64'd0);
      issue(4'd10, 32'd1, 32'd12, 1'b0);
      wait_idle(c);
      chk("msubu_hi", 64'(hi_o), 64'hFFFF_FFFF);
      chk("msubu_lo", 64'(lo_o), 64'hFFFF_FFFF);
`else
      chk("madd_noop_busy", 64'(c), 64'd0);
      chk("madd_noop_lo", 64'(lo_o), 64'd5);
`endif

      for (int n = 0; n < 150; n++) begin
         rop = 4'($urandom_range(0, 12));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         issue(rop, ra, rb, ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            #1 annul_i = 1'b1;
            @(posedge clk);
            #1 annul_i = 1'b0;
         end
         wait_idle(c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
